// File: rtl/pmem_burst_adaptor_pkg.sv
`default_nettype none
// ============================================================================
// Module : lc3b_types (package)
// Brief  : Shared line/beat types and line geometry constants.
// Rev    : 1.0
// ============================================================================
package lc3b_types;
    typedef logic [127:0] lc3b_line;
    typedef logic [31:0]  lc3b_beat;

    localparam int LINE_OFFSET_BITS = 4;
    localparam int LINE_W           = 128;
endpackage
`default_nettype wire

// File: rtl/pmem_burst_adaptor_line_buf.sv
`default_nettype none
// ============================================================================
// Module : line_beat_buffer
// Brief  : 128-bit line register with full-line load and indexed beat access.
// Rev    : 1.0
// ============================================================================
module line_beat_buffer
    import lc3b_types::*;
#(
    parameter int BEAT_W = 32,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  lc3b_line          load_line_i,
    input  logic              beat_we_i,
    input  logic [IDX_W-1:0]  beat_widx_i,
    input  logic [BEAT_W-1:0] beat_wdata_i,
    input  logic [IDX_W-1:0]  beat_ridx_i,
    output lc3b_line          line_o,
    output logic [BEAT_W-1:0] beat_o
);

    lc3b_line line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else if (load_i) begin
            line_q <= load_line_i;
        end else if (beat_we_i) begin
            line_q[int'(beat_widx_i)*BEAT_W +: BEAT_W] <= beat_wdata_i;
        end
    end

    assign line_o = line_q;
    assign beat_o = line_q[int'(beat_ridx_i)*BEAT_W +: BEAT_W];

endmodule
`default_nettype wire

// File: rtl/pmem_burst_adaptor.sv
`default_nettype none
// ============================================================================
// Module : pmem_burst_adaptor
// Brief  : Turns one 128-bit cache-line read/write into a multi-beat burst.
// Rev    : 1.0
// ============================================================================
module pmem_burst_adaptor
    import lc3b_types::*;
#(
    parameter int BEAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [15:0]       pmem_address,
    input  lc3b_line          pmem_wdata,
    output logic              pmem_resp,
    output lc3b_line          pmem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [15:0]       mem_address,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic              mem_wready
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int IDX_W = $clog2(BEATS);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [15:0]      addr_q, addr_d;
    logic             w_wload;
    logic             w_rbeat_we;
    logic [BEAT_W-1:0] w_wbeat;
    logic [BEAT_W-1:0] w_rbuf_beat_unused;
    lc3b_line          w_wbuf_line_unused;
    logic [LINE_OFFSET_BITS-1:0] w_addr_offset_unused;

    assign w_addr_offset_unused = pmem_address[LINE_OFFSET_BITS-1:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        w_wload    = 1'b0;
        w_rbeat_we = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Read has priority when the cache illegally raises both.
                if (pmem_read || pmem_write) begin
                    addr_d  = {pmem_address[15:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
                    cnt_d   = '0;
                    state_d = pmem_read ? S_READ : S_WRITE;
                    w_wload = !pmem_read;
                end
            end
            S_READ: begin
                if (mem_rvalid) begin
                    w_rbeat_we = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = S_RESP;
                end
            end
            S_WRITE: begin
                if (mem_wready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    line_beat_buffer #(.BEAT_W(BEAT_W), .IDX_W(IDX_W)) u_rbuf (
        .clk         (clk),
        .rst         (rst),
        .load_i      (1'b0),
        .load_line_i ('0),
        .beat_we_i   (w_rbeat_we),
        .beat_widx_i (cnt_q),
        .beat_wdata_i(mem_rdata),
        .beat_ridx_i (cnt_q),
        .line_o      (pmem_rdata),
        .beat_o      (w_rbuf_beat_unused)
    );

    line_beat_buffer #(.BEAT_W(BEAT_W), .IDX_W(IDX_W)) u_wbuf (
        .clk         (clk),
        .rst         (rst),
        .load_i      (w_wload),
        .load_line_i (pmem_wdata),
        .beat_we_i   (1'b0),
        .beat_widx_i ('0),
        .beat_wdata_i('0),
        .beat_ridx_i (cnt_q),
        .line_o      (w_wbuf_line_unused),
        .beat_o      (w_wbeat)
    );

    assign pmem_resp   = (state_q == S_RESP);
    assign mem_read    = (state_q == S_READ);
    assign mem_write   = (state_q == S_WRITE);
    assign mem_address = addr_q;
    assign mem_wdata   = mem_write ? w_wbeat : '0;

endmodule
`default_nettype wire

// File: tb/tb_pmem_burst_adaptor.sv
`default_nettype none
// ============================================================================
// Module : tb_pmem_burst_adaptor
// Brief  : Randomised scoreboard bench for the line-to-burst adaptor.
// Rev    : 1.0
// ============================================================================
module tb_pmem_burst_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic         mem_read, mem_write;
    logic [15:0]  mem_address;
    logic [31:0]  mem_rdata;
    logic         mem_rvalid;
    logic [31:0]  mem_wdata;
    logic         mem_wready;

    always #5 clk = ~clk;

    pmem_burst_adaptor #(.BEAT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_resp   (pmem_resp),
        .pmem_rdata  (pmem_rdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .mem_wdata   (mem_wdata),
        .mem_wready  (mem_wready)
    );

    typedef struct {
        bit           is_rd;
        logic [127:0] rdata;
        logic [15:0]  addr;
        int           start;
        int           lat;
    } exp_t;

    exp_t         expq[$];
    logic [31:0]  wbq[$];
    logic [127:0] model_line = '0;
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, logic [127:0] act, logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard on each response and checks beats/bursts.
    initial begin
        exp_t e;
        bit   prev_rd = 1'b0;
        bit   prev_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (pmem_resp) begin
                if (expq.size() == 0) begin
                    check("spurious_resp", 128'(pmem_resp), 128'(0));
                end else begin
                    e = expq.pop_front();
                    check("resp_rdata", pmem_rdata, e.rdata);
                    check("resp_cycle", 128'(cyc), 128'(e.start + e.lat));
                end
            end
            if (expq.size() > 0) begin
                if ((mem_read && !prev_rd) || (mem_write && !prev_wr)) begin
                    check("burst_start", 128'(cyc), 128'(expq[0].start + 1));
                    check("mem_address", 128'(mem_address), 128'(expq[0].addr));
                    check("burst_kind", 128'(mem_read), 128'(expq[0].is_rd));
                end
                if (mem_write && expq[0].is_rd)
                    check("write_during_read", 128'(mem_write), 128'(0));
            end
            if (mem_write && mem_wready) begin
                if (wbq.size() == 0) check("extra_wbeat", 128'(mem_write), 128'(0));
                else check("wbeat", 128'(mem_wdata), 128'(wbq.pop_front()));
            end
            prev_rd = mem_read;
            prev_wr = mem_write;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // gapmode 0: no gaps, 1: gap on every other cycle starting with a gap, 2: random
    task automatic run_txn(input bit rd, input bit wr, input logic [15:0] addr,
                           input logic [127:0] line, input int gapmode);
        exp_t e;
        bit   gaps[$];
        int   n = 0;
        int   i = 0;
        int   to = 0;
        while (n < 4) begin
            bit g;
            g = (gapmode == 1) ? (gaps.size() % 2 == 0) :
                (gapmode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            gaps.push_back(g);
            if (!g) n++;
        end
        step();
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = rd ? {$urandom, $urandom, $urandom, $urandom} : line;
        mem_rvalid   = 1'($urandom);
        mem_wready   = 1'($urandom);
        mem_rdata    = $urandom;
        e.is_rd = rd;
        e.addr  = {addr[15:4], 4'h0};
        e.start = cyc;
        e.lat   = gaps.size() + 1;
        if (rd) model_line = line;
        else for (int k = 0; k < 4; k++) wbq.push_back(line[k*32 +: 32]);
        e.rdata = model_line;
        expq.push_back(e);
        foreach (gaps[j]) begin
            step();
            mem_rvalid = rd && !gaps[j];
            mem_wready = !rd && !gaps[j];
            mem_rdata  = gaps[j] ? $urandom : line[i*32 +: 32];
            if (!gaps[j]) i++;
        end
        step();
        mem_rvalid = 1'($urandom);
        mem_wready = 1'($urandom);
        mem_rdata  = $urandom;
        while (!pmem_resp && to < 20) begin
            step();
            to++;
        end
        if (to == 20) check("resp_timeout", 128'(pmem_resp), 128'(1));
        step();
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        mem_rvalid = 1'($urandom);
        mem_wready = 1'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0; pmem_wdata = '0;
        mem_rdata = '0; mem_rvalid = 1'b0; mem_wready = 1'b0;
        repeat (3) step();
        check("rst_resp", 128'(pmem_resp), 128'(0));
        check("rst_rdata", pmem_rdata, 128'(0));
        check("rst_mem_read", 128'(mem_read), 128'(0));
        check("rst_mem_write", 128'(mem_write), 128'(0));
        check("rst_mem_address", 128'(mem_address), 128'(0));
        check("rst_mem_wdata", 128'(mem_wdata), 128'(0));
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("idle_resp", 128'(pmem_resp), 128'(0));
            check("idle_mem_rw", 128'({mem_read, mem_write}), 128'(0));
        end

        run_txn(1'b1, 1'b0, 16'h1234, 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000, 0);
        run_txn(1'b0, 1'b1, 16'h2000, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 1);
        run_txn(1'b1, 1'b1, 16'h3456, {$urandom, $urandom, $urandom, $urandom}, 2);

        // Read aborted by reset after its second beat.
        step();
        pmem_read = 1'b1; pmem_address = 16'h4444; mem_rvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
        end
        step();
        rst = 1'b1;
        pmem_read = 1'b0;
        step();
        rst = 1'b0;
        mem_rvalid = 1'b0;
        model_line = '0;
        check("abort_mem_read", 128'(mem_read), 128'(0));
        check("abort_rdata", pmem_rdata, 128'(0));
        check("abort_resp", 128'(pmem_resp), 128'(0));
        check("abort_mem_address", 128'(mem_address), 128'(0));
        repeat (3) step();

        run_txn(1'b1, 1'b0, 16'h5010, {$urandom, $urandom, $urandom, $urandom}, 0);
        run_txn(1'b1, 1'b0, 16'h5020, {$urandom, $urandom, $urandom, $urandom}, 0);

        for (int t = 0; t < 40; t++) begin
            bit r;
            r = 1'($urandom);
            run_txn(r, !r || ($urandom_range(0, 7) == 0), 16'($urandom),
                    {$urandom, $urandom, $urandom, $urandom}, 2);
        end

        repeat (4) step();
        check("expq_drained", 128'(expq.size()), 128'(0));
        check("wbq_drained", 128'(wbq.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
